// File: rtl/coef_fetch_eval.sv
// Coefficient ROM initiator: segments a Q0.XW sample by leading zeros and evaluates (C2*xr + C1)*xr + C0.
// Result is valid 4 cycles after accept; it is held in DONE until out_ready, and no new sample is taken meanwhile.
module coef_fetch_eval #(
  parameter int XW   = 16,
  parameter int NSEG = 10,
  parameter int FRAC = XW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] x_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [6:0]    address,
  output logic          read_en,
  input  logic [17:0]   Coef2,
  input  logic [17:0]   Coef1,
  input  logic [20:0]   Coef0,
  output logic [20:0]   y_out,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int LZW = $clog2(XW + 1);
  localparam int P1W = 18 + XW;
  localparam int P2W = 20 + XW;
  localparam logic signed [23:0] Y_MAX = 24'sd1048575;
  localparam logic signed [23:0] Y_MIN = -24'sd1048576;

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, MUL1, MUL2, DONE} state_t;
  state_t state, state_nxt;

  logic [LZW-1:0]           lzc, lz;
  logic [6:0]               addr_d, addr_q;
  logic [FRAC-1:0]          xr_d, xr_q;
  logic signed [17:0]       c2_q, c1_q;
  logic signed [20:0]       c0_q;
  logic signed [XW-1:0]     xr_ext;
  logic signed [P1W-1:0]    p1;
  logic signed [P2W-1:0]    p2;
  logic signed [19:0]       s1_d, s1_q;
  logic signed [23:0]       acc;
  logic signed [20:0]       y_sat, y_q;

  // Segment derivation; the shift count is capped so the last segment absorbs all small samples.
  always_comb begin
    lzc = LZW'(XW);
    for (int i = 0; i < XW; i++) begin
      if (x_in[i]) lzc = LZW'(XW - 1 - i);
    end
    lz     = (lzc > LZW'(NSEG - 1)) ? LZW'(NSEG - 1) : lzc;
    xr_d   = FRAC'(x_in << lz);
    addr_d = 7'(lz) + 7'd1;
  end

  // Horner datapath; the size casts sign-extend the operands before multiplying.
  always_comb begin
    xr_ext = $signed({1'b0, xr_q});
    p1     = P1W'(c2_q) * P1W'(xr_ext);
    s1_d   = 20'(p1 >>> FRAC) + 20'(c1_q);
    p2     = P2W'(s1_q) * P2W'(xr_ext);
    acc    = 24'(p2 >>> FRAC) + 24'(c0_q);
    if (acc > Y_MAX)      y_sat = 21'h0FFFFF;
    else if (acc < Y_MIN) y_sat = 21'h100000;
    else                  y_sat = acc[20:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    read_en   = 1'b0;
    address   = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = FETCH;
      end
      FETCH: begin
        read_en   = 1'b1;
        address   = addr_q;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = MUL1;
      MUL1: state_nxt = MUL2;
      MUL2: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ROM is combinational, so its words are captured on the edge that leaves FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      xr_q   <= '0;
      c2_q   <= '0;
      c1_q   <= '0;
      c0_q   <= '0;
      s1_q   <= '0;
      y_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          addr_q <= addr_d;
          xr_q   <= xr_d;
        end
        FETCH: begin
          c2_q <= $signed(Coef2);
          c1_q <= $signed(Coef1);
          c0_q <= $signed(Coef0);
        end
        MUL1:    s1_q <= s1_d;
        MUL2:    y_q  <= y_sat;
        default: ;
      endcase
    end
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_coef_fetch_eval.sv
// Directed and scoreboarded checks for coef_fetch_eval against a combinational ROM model.
module tb_coef_fetch_eval;

  logic        clk;
  logic        rst;
  logic [15:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  address;
  logic        read_en;
  logic [17:0] Coef2;
  logic [17:0] Coef1;
  logic [20:0] Coef0;
  logic [20:0] y_out;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int failures = 0;

  logic [6:0] exp_addr[$];
  int         exp_y[$];

  localparam int ROM_C2 [0:10] = '{0, 0, 0, -20000, 0, 70000, -131072, 99999, -1, 12345, 0};
  localparam int ROM_C1 [0:10] = '{0, 0, 131071, 5000, -131072, -40000, 131071, -1, -99999, 54321, 32768};
  localparam int ROM_C0 [0:10] = '{0, 1000, 1048575, -300, -1048576, 123456, -500000, 42, -7, -999999, 5};

  coef_fetch_eval dut (
    .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .read_en(read_en), .Coef2(Coef2), .Coef1(Coef1), .Coef0(Coef0),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rom_idx;
  always_comb begin
    rom_idx = int'(address);
    Coef2 = '0;
    Coef1 = '0;
    Coef0 = '0;
    if (rom_idx >= 1 && rom_idx <= 10) begin
      Coef2 = 18'(ROM_C2[rom_idx]);
      Coef1 = 18'(ROM_C1[rom_idx]);
      Coef0 = 21'(ROM_C0[rom_idx]);
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference: find the leading one, clamp the segment, then floor-shifted Horner with clamping.
  function automatic void model(input logic [15:0] x, output logic [6:0] a, output int y);
    int lz;
    longint xr, s1, acc;
    lz = 0;
    while (lz < 16 && x[15-lz] == 1'b0) lz++;
    if (lz > 9) lz = 9;
    a   = 7'(lz + 1);
    xr  = (longint'(x) << lz) & 64'h7FFF;
    s1  = ((longint'(ROM_C2[lz+1]) * xr) >>> 15) + longint'(ROM_C1[lz+1]);
    acc = ((s1 * xr) >>> 15) + longint'(ROM_C0[lz+1]);
    if (acc > 1048575)  acc = 1048575;
    if (acc < -1048576) acc = -1048576;
    y = int'(acc);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (read_en) begin
        chk("rom_read_expected", int'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) chk("rom_address", int'(address), int'(exp_addr.pop_front()));
      end
      if (out_valid && out_ready) begin
        chk("output_expected", int'(exp_y.size() != 0), 1);
        if (exp_y.size() != 0) chk("y_out", int'($signed(y_out)), exp_y.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [6:0] ea, input int ey);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", int'(in_ready), 1);
    exp_addr.push_back(ea);
    exp_y.push_back(ey);
    x_in = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in = 16'hFFFF;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    chk("done_timeout", int'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xr;
    logic [6:0]  ea;
    int          ey;

    rst = 1'b1;
    x_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_read_en", int'(read_en), 0);
    chk("rst_address", int'(address), 0);
    chk("rst_y_out", int'(y_out), 0);
    @(posedge clk); #1;

    // Segment 1 with cycle-accurate latency checks.
    send(16'h8000, 7'd1, 1000);
    @(negedge clk);
    chk("fetch_read_en", int'(read_en), 1);
    chk("fetch_address", int'(address), 1);
    chk("fetch_in_ready", int'(in_ready), 0);
    repeat (3) begin
      @(negedge clk);
      chk("busy_read_en", int'(read_en), 0);
      chk("busy_out_valid", int'(out_valid), 0);
      chk("busy_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    chk("lat4_out_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("one_cycle_out_valid", int'(out_valid), 0);
    chk("back_idle_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    send(16'h0001, 7'd10, 517);      wait_done();
    send(16'h7FFF, 7'd2, 1048575);   wait_done();
    send(16'h3000, 7'd3, -2800);     wait_done();
    send(16'h1FFF, 7'd4, -1048576);  wait_done();
    send(16'h0000, 7'd10, 5);        wait_done();

    // Backpressure: result held, inputs ignored while DONE waits.
    out_ready = 1'b0;
    send(16'h0001, 7'd10, 517);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 30);
      chk("bp_reach_done", int'(out_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      x_in = 16'($urandom);
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_y_out", int'($signed(y_out)), 517);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_read_en", int'(read_en), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Reset while in MUL1 drops the sample in flight.
    send(16'h8000, 7'd1, 1000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_y.pop_back());
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_y_out", int'(y_out), 0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_quiet", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(16'h8000, 7'd1, 1000);
    wait_done();

    // Back-to-back random samples against the reference model.
    repeat (8) begin
      xr = 16'($urandom_range(1, 65535));
      model(xr, ea, ey);
      send(xr, ea, ey);
    end
    wait_done();

    repeat (8) @(negedge clk);
    chk("drain_y", exp_y.size(), 0);
    chk("drain_addr", exp_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
